// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller sitting between fetch/EX and the PC register.
// Arbitrates sequential fetch, branch/jump redirect, trap entry and eret, merges
// the stall sources into a single PC freeze and raises the IF/ID and ID/EX flushes.
// Optional feature: define PC_SEQ_PERF_EN to add the stall_cycles and
// redirect_count performance counter outputs.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module pc_sequencer #(
    parameter logic [`WORD_WIDTH-1:0] TRAP_VECTOR  = `WORD_WIDTH'('h80),
    parameter int unsigned            DRAIN_CYCLES = 2,
    parameter int unsigned            INSTR_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`WORD_WIDTH-1:0] pc,
    input  logic                   imem_ready,
    input  logic                   hazard_stall,
    input  logic                   mdu_busy,
    input  logic                   branch_taken,
    input  logic                   jump_en,
    input  logic [`WORD_WIDTH-1:0] target,
    input  logic                   trap_req,
    input  logic                   eret,
    output logic [`WORD_WIDTH-1:0] pc_next,
    output logic                   pc_freeze,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic [`WORD_WIDTH-1:0] epc,
    output logic [1:0]             cause
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            redirect_count
`endif
);

    localparam int unsigned            CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [`WORD_WIDTH-1:0] PC_INC     = `WORD_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [`WORD_WIDTH-1:0]   pend_tgt;
    logic [CNT_W-1:0]         drain_cnt;

    logic                     redirect;
    logic                     misaligned;
    logic                     stall;
    logic                     take_trap;
    logic                     eret_accept;
    logic                     load_pend;
    logic [`WORD_WIDTH-1:0]   eff_tgt;

    assign redirect   = branch_taken | jump_en;
    // A misaligned redirect never reaches the PC; it becomes a trap instead.
    assign misaligned = redirect & (target[1:0] != 2'b00);
    assign stall      = hazard_stall | mdu_busy | ~imem_ready;

    // Next-state and PC-register control: trap > eret > redirect > stall > sequential.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // a value unassigned and no latch is inferred.
        state_next  = state;
        pc_next     = pc + PC_INC;
        pc_freeze   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        take_trap   = 1'b0;
        eret_accept = 1'b0;
        load_pend   = 1'b0;
        eff_tgt     = eret ? epc : target;

        if (state == DRAIN) begin
            // Trap drain ignores every request; it only waits out the counter and fetch.
            pc_freeze   = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_next     = pc;
            if (drain_cnt == '0 && imem_ready) begin
                pc_next    = TRAP_VECTOR;
                pc_freeze  = 1'b0;
                state_next = RUN;
            end
        end else if (trap_req || misaligned) begin
            take_trap   = 1'b1;
            pc_freeze   = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_next     = pc;
            state_next  = DRAIN;
        end else if (eret || redirect) begin
            // The stalled instruction is killed by the flush, so hazard/mdu stalls do not hold a redirect.
            eret_accept = eret;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (imem_ready) begin
                pc_next    = eff_tgt;
                state_next = RUN;
            end else begin
                pc_next    = pc;
                pc_freeze  = 1'b1;
                load_pend  = 1'b1;
                state_next = PEND;
            end
        end else if (state == PEND) begin
            if (imem_ready) begin
                pc_next    = pend_tgt;
                state_next = RUN;
            end else begin
                pc_next   = pc;
                pc_freeze = 1'b1;
            end
        end else if (stall) begin
            pc_next    = pc;
            pc_freeze  = 1'b1;
            state_next = STALL;
        end else begin
            state_next = RUN;
        end
    end

    // State register, drain counter, held redirect target and trap bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            pend_tgt  <= '0;
            epc       <= '0;
            cause     <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state <= state_next;
            if (take_trap) begin
                drain_cnt <= DRAIN_LOAD;
                epc       <= (state == PEND) ? pend_tgt : pc;
                cause     <= trap_req ? 2'd1 : 2'd2;
            end else begin
                if (state == DRAIN && drain_cnt != '0) begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
                if (eret_accept) begin
                    cause <= 2'd0;
                end
            end
            if (load_pend) begin
                pend_tgt <= eff_tgt;
            end
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic redirect_applied;

    // A redirect, eret or held target is applied whenever the PC moves outside DRAIN
    // on a cycle that had one pending or requested.
    assign redirect_applied = ~pc_freeze & (state != DRAIN) & ((state == PEND) | eret | redirect);

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (pc_freeze && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_applied && redirect_count != '1) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule
